// File: rtl/alu_iter_seq_pkg.sv
// Shared encodings for the MUL/DIVU sequencer: ALU opcodes, FSM states and
// the op_div request encoding.
package alu_iter_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SHL  = 4'b1010;
  localparam logic [3:0] ALU_GEU  = 4'b1011;
  localparam logic [3:0] ALU_ZERO = 4'b1111;

  localparam logic OP_MUL  = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M_ADD = 3'd1,
    ST_M_SHL = 3'd2,
    ST_D_SHF = 3'd3,
    ST_D_CMP = 3'd4,
    ST_D_SUB = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/alu_iter_seq_if.sv
// Request/response and ALU-drive signals of the MUL/DIVU sequencer.
// slave is the sequencer side; master is the requester/ALU side.
interface alu_iter_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op_div;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result_lo;
  logic [DATA_W-1:0] result_hi;
  logic [DATA_W-1:0] alu_in_1;
  logic [DATA_W-1:0] alu_in_2;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_bcond;

  modport slave (
    input  start, op_div, src_a, src_b, alu_result, alu_bcond,
    output busy, done, result_lo, result_hi, alu_in_1, alu_in_2, alu_op
  );

  modport master (
    output start, op_div, src_a, src_b, alu_result, alu_bcond,
    input  busy, done, result_lo, result_hi, alu_in_1, alu_in_2, alu_op
  );
endinterface

// File: rtl/alu_iter_seq.sv
// Multicycle MUL (shift-add, low word) / DIVU (restoring) sequencer that
// borrows the external combinational ALU for every arithmetic step.
module alu_iter_seq
  import alu_iter_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_iter_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mc_q, mc_d;
  logic [DATA_W-1:0] mp_q, mp_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and datapath update; results are loaded on the DONE entry edge.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op_div == OP_MUL) begin
            acc_d   = '0;
            mc_d    = bus.src_a;
            mp_d    = bus.src_b;
            cnt_d   = '0;
            state_d = ST_M_ADD;
          end else if (bus.src_b == '0) begin
            res_lo_d = '1;
            res_hi_d = bus.src_a;
            state_d  = ST_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = bus.src_a;
            dvs_d   = bus.src_b;
            cnt_d   = '0;
            state_d = ST_D_SHF;
          end
        end
      end
      ST_M_ADD: begin
        if (mp_q[0]) acc_d = bus.alu_result;
        state_d = ST_M_SHL;
      end
      ST_M_SHL: begin
        mc_d  = bus.alu_result;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_lo_d = acc_q;
          res_hi_d = '0;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_M_ADD;
        end
      end
      ST_D_SHF: begin
        rem_d   = bus.alu_result | DATA_W'(quo_q[DATA_W-1]);
        quo_d   = quo_q << 1;
        state_d = ST_D_CMP;
      end
      ST_D_CMP: begin
        if (bus.alu_bcond) begin
          quo_d   = quo_q | DATA_W'(1);
          state_d = ST_D_SUB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            res_lo_d = quo_q;
            res_hi_d = rem_q;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_D_SHF;
          end
        end
      end
      ST_D_SUB: begin
        rem_d = bus.alu_result;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_lo_d = quo_q;
          res_hi_d = bus.alu_result;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_D_SHF;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ALU drive is a pure Moore decode of the registered state and operands.
  always_comb begin
    bus.alu_op   = ALU_ZERO;
    bus.alu_in_1 = '0;
    bus.alu_in_2 = '0;
    case (state_q)
      ST_M_ADD: begin
        bus.alu_op   = ALU_ADD;
        bus.alu_in_1 = acc_q;
        bus.alu_in_2 = mc_q;
      end
      ST_M_SHL: begin
        bus.alu_op   = ALU_SHL;
        bus.alu_in_1 = mc_q;
      end
      ST_D_SHF: begin
        bus.alu_op   = ALU_SHL;
        bus.alu_in_1 = rem_q;
      end
      ST_D_CMP: begin
        bus.alu_op   = ALU_GEU;
        bus.alu_in_1 = rem_q;
        bus.alu_in_2 = dvs_q;
      end
      ST_D_SUB: begin
        bus.alu_op   = ALU_SUB;
        bus.alu_in_1 = rem_q;
        bus.alu_in_2 = dvs_q;
      end
      default: begin
        bus.alu_op   = ALU_ZERO;
        bus.alu_in_1 = '0;
        bus.alu_in_2 = '0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;

endmodule
